// File: rtl/input_manager_if.sv
// Held-key levels in, single-cycle action pulses out: the link between the
// keyboard decoder, input_manager and game_control.
interface input_manager_if;
    logic tick_game;
    logic enable;
    logic left_held;
    logic right_held;
    logic down_held;
    logic rotate_held;
    logic drop_held;
    logic key_left;
    logic key_right;
    logic key_down;
    logic key_rotate;
    logic key_drop;

    modport slave (
        input  tick_game, enable,
        input  left_held, right_held, down_held, rotate_held, drop_held,
        output key_left, key_right, key_down, key_rotate, key_drop
    );

    modport master (
        output tick_game, enable,
        output left_held, right_held, down_held, rotate_held, drop_held,
        input  key_left, key_right, key_down, key_rotate, key_drop
    );
endinterface

// File: rtl/input_manager.sv
// Turns held-key levels into game_control action pulses: edge pulses for rotate/drop,
// DAS + auto-repeat for left/right, repeat for soft drop. Optional input filter: DEBOUNCE_EN.
module input_manager #(
    parameter int DAS_TICKS       = 10,
    parameter int ARR_TICKS       = 2,
    parameter int SOFT_DROP_TICKS = 3
`ifdef DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 16
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input_manager_if.slave bus
);
    typedef enum logic [1:0] {
        H_IDLE,
        H_DAS,
        H_REPEAT
    } h_state_t;

    localparam int K_LEFT  = 0;
    localparam int K_RIGHT = 1;
    localparam int K_DOWN  = 2;
    localparam int K_ROT   = 3;
    localparam int K_DROP  = 4;

    localparam logic [7:0] LP_DAS = 8'(DAS_TICKS);
    localparam logic [7:0] LP_ARR = 8'(ARR_TICKS);
    localparam logic [7:0] LP_SD  = 8'(SOFT_DROP_TICKS);

    logic [4:0] w_raw;
    logic [4:0] w_level;

    assign w_raw = {bus.drop_held, bus.rotate_held, bus.down_held,
                    bus.right_held, bus.left_held};

`ifdef DEBOUNCE_EN
    localparam logic [15:0] LP_DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [4:0]  r_sync1;
    logic [4:0]  r_sync2;
    logic [4:0]  r_filt;
    logic [15:0] r_deb_cnt [5];

    // The filtered level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            // NOTE: this array is five control counters, not storage, so it is reset like any flop.
            for (int k = 0; k < 5; k++) r_deb_cnt[k] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int k = 0; k < 5; k++) begin
                if (r_sync2[k] == r_filt[k]) begin
                    r_deb_cnt[k] <= '0;
                end else if (r_deb_cnt[k] >= LP_DEB_LAST) begin
                    r_filt[k]    <= r_sync2[k];
                    r_deb_cnt[k] <= '0;
                end else begin
                    r_deb_cnt[k] <= r_deb_cnt[k] + 16'd1;
                end
            end
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = w_raw;
`endif

    logic [4:0] r_prev;
    logic       r_armed;
    logic [4:0] w_edge;
    logic       w_live;

    assign w_edge = w_level & ~r_prev;
    // r_armed stays low for the first cycle after reset so keys held through reset do not pulse.
    assign w_live = bus.enable & r_armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev  <= '0;
            r_armed <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, order-independent.
            r_prev  <= w_level;
            r_armed <= 1'b1;
        end
    end

    logic r_key_rotate;
    logic r_key_drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key_rotate <= 1'b0;
            r_key_drop   <= 1'b0;
        end else begin
            r_key_rotate <= w_live & w_edge[K_ROT];
            r_key_drop   <= w_live & w_edge[K_DROP];
        end
    end

    logic       r_sd_active;
    logic [7:0] r_sd_cnt;
    logic [7:0] w_sd_cnt_inc;
    logic       r_key_down;

    assign w_sd_cnt_inc = (r_sd_cnt == 8'hFF) ? 8'hFF : r_sd_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sd_active <= 1'b0;
            r_sd_cnt    <= '0;
            r_key_down  <= 1'b0;
        end else begin
            r_key_down <= 1'b0;
            if (!w_live || !w_level[K_DOWN]) begin
                r_sd_active <= 1'b0;
                r_sd_cnt    <= '0;
            end else if (w_edge[K_DOWN]) begin
                r_key_down  <= 1'b1;
                r_sd_active <= 1'b1;
                r_sd_cnt    <= '0;
            end else if (r_sd_active && bus.tick_game) begin
                if (w_sd_cnt_inc >= LP_SD) begin
                    r_key_down <= 1'b1;
                    r_sd_cnt   <= '0;
                end else begin
                    r_sd_cnt <= w_sd_cnt_inc;
                end
            end
        end
    end

    h_state_t   r_h_state;
    logic       r_dir;
    logic [7:0] r_h_cnt;
    logic [7:0] w_h_cnt_inc;
    logic [7:0] w_h_limit;
    logic       w_act_held;
    logic       w_opp_held;
    logic       w_opp_edge;
    logic       r_key_left;
    logic       r_key_right;

    assign w_h_cnt_inc = (r_h_cnt == 8'hFF) ? 8'hFF : r_h_cnt + 8'd1;
    assign w_h_limit   = (r_h_state == H_DAS) ? LP_DAS : LP_ARR;
    assign w_act_held  = r_dir ? w_level[K_RIGHT] : w_level[K_LEFT];
    assign w_opp_held  = r_dir ? w_level[K_LEFT]  : w_level[K_RIGHT];
    assign w_opp_edge  = r_dir ? w_edge[K_LEFT]   : w_edge[K_RIGHT];

    // r_dir: 0 = left, 1 = right. A switch pulses the new direction, i.e. the old ~r_dir.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h_state   <= H_IDLE;
            r_dir       <= 1'b0;
            r_h_cnt     <= '0;
            r_key_left  <= 1'b0;
            r_key_right <= 1'b0;
        end else begin
            r_key_left  <= 1'b0;
            r_key_right <= 1'b0;
            if (!w_live) begin
                r_h_state <= H_IDLE;
                r_h_cnt   <= '0;
            end else begin
                unique case (r_h_state)
                    H_IDLE: begin
                        if (w_edge[K_LEFT] || w_edge[K_RIGHT]) begin
                            r_dir       <= ~w_edge[K_LEFT];
                            r_key_left  <= w_edge[K_LEFT];
                            r_key_right <= ~w_edge[K_LEFT];
                            r_h_cnt     <= '0;
                            r_h_state   <= H_DAS;
                        end
                    end
                    H_DAS, H_REPEAT: begin
                        if (!w_act_held && !w_opp_held) begin
                            r_h_cnt   <= '0;
                            r_h_state <= H_IDLE;
                        end else if (!w_act_held || w_opp_edge) begin
                            r_dir       <= ~r_dir;
                            r_key_left  <= r_dir;
                            r_key_right <= ~r_dir;
                            r_h_cnt     <= '0;
                            r_h_state   <= H_DAS;
                        end else if (bus.tick_game) begin
                            if (w_h_cnt_inc >= w_h_limit) begin
                                r_key_left  <= ~r_dir;
                                r_key_right <= r_dir;
                                r_h_cnt     <= '0;
                                r_h_state   <= H_REPEAT;
                            end else begin
                                r_h_cnt <= w_h_cnt_inc;
                            end
                        end
                    end
                    default: begin
                        r_h_state <= H_IDLE;
                        r_h_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.key_left   = r_key_left;
    assign bus.key_right  = r_key_right;
    assign bus.key_down   = r_key_down;
    assign bus.key_rotate = r_key_rotate;
    assign bus.key_drop   = r_key_drop;
endmodule

// File: tb/tb_input_manager.sv
// Self-checking bench for input_manager: constant vector table, directed multi-cycle
// sequences and a random run against a tick-counting reference model.
`timescale 1ns/1ps
module tb_input_manager;
    localparam int DAS = 10;
    localparam int ARR = 2;
    localparam int SDT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    input_manager_if u_if ();

    input_manager #(
        .DAS_TICKS      (DAS),
        .ARR_TICKS      (ARR),
        .SOFT_DROP_TICKS(SDT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if)
    );

    typedef struct {
        logic       tick;
        logic       en;
        logic [4:0] held;   // {drop, rotate, down, right, left}
        logic [4:0] exp;    // {drop, rotate, down, right, left}
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: tracks which direction is live, ticks since its last pulse and
    // how many pulses this run has produced (the first repeat waits DAS, later ones ARR).
    logic [4:0] m_prev;
    logic       m_fresh;
    int         m_act;
    int         m_ticks;
    int         m_run;
    logic       m_sd_on;
    int         m_sd_t;
    logic [4:0] m_exp;

    logic [31:0] pl_mask, pr_mask, pd_mask;
    int          n_pulses, n_stray, g_tick;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [4:0] outs();
        return {u_if.key_drop, u_if.key_rotate, u_if.key_down, u_if.key_right, u_if.key_left};
    endfunction

    function automatic logic [4:0] get_held();
        return {u_if.drop_held, u_if.rotate_held, u_if.down_held, u_if.right_held, u_if.left_held};
    endfunction

    task automatic set_held(input logic [4:0] h);
        {u_if.drop_held, u_if.rotate_held, u_if.down_held, u_if.right_held, u_if.left_held} = h;
    endtask

    task automatic model_reset();
        m_prev  = '0;
        m_fresh = 1'b1;
        m_act   = -1;
        m_ticks = 0;
        m_run   = 0;
        m_sd_on = 1'b0;
        m_sd_t  = 0;
        m_exp   = '0;
    endtask

    task automatic model_fire(input int d, input logic new_run);
        m_act    = d;
        m_exp[d] = 1'b1;
        m_ticks  = 0;
        m_run    = new_run ? 1 : m_run + 1;
    endtask

    task automatic model_step();
        logic [4:0] h;
        logic [4:0] e;
        logic       live;
        int         o;
        h       = get_held();
        e       = h & ~m_prev;
        m_prev  = h;
        m_exp   = '0;
        live    = !m_fresh && u_if.enable;
        m_fresh = 1'b0;
        if (!live) begin
            m_act   = -1;
            m_ticks = 0;
            m_sd_on = 1'b0;
            m_sd_t  = 0;
            return;
        end
        m_exp[3] = e[3];
        m_exp[4] = e[4];
        if (m_act < 0) begin
            if (e[0])      model_fire(0, 1'b1);
            else if (e[1]) model_fire(1, 1'b1);
        end else begin
            o = 1 - m_act;
            if (!h[m_act]) begin
                if (h[o]) model_fire(o, 1'b1);
                else      m_act = -1;
            end else if (e[o]) begin
                model_fire(o, 1'b1);
            end else if (u_if.tick_game) begin
                m_ticks++;
                if (m_ticks >= ((m_run == 1) ? DAS : ARR)) model_fire(m_act, 1'b0);
            end
        end
        if (!h[2]) begin
            m_sd_on = 1'b0;
            m_sd_t  = 0;
        end else if (e[2]) begin
            m_exp[2] = 1'b1;
            m_sd_on  = 1'b1;
            m_sd_t   = 0;
        end else if (m_sd_on && u_if.tick_game) begin
            m_sd_t++;
            if (m_sd_t >= SDT) begin
                m_exp[2] = 1'b1;
                m_sd_t   = 0;
            end
        end
    endtask

    // One clock: inputs already driven, DUT samples them, outputs read 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else      model_step();
    endtask

    task automatic clr_rec();
        pl_mask = '0; pr_mask = '0; pd_mask = '0;
        n_pulses = 0; n_stray = 0; g_tick = 0;
    endtask

    // Each tick: three quiet cycles then one tick_game cycle; pulses logged by tick index.
    task automatic run_ticks(input int n);
        for (int t = 0; t < n; t++) begin
            u_if.tick_game = 1'b0;
            for (int q = 0; q < 3; q++) begin
                step();
                n_pulses += $countones(outs());
                if (outs() & 5'b00111) n_stray++;
            end
            u_if.tick_game = 1'b1;
            g_tick++;
            step();
            n_pulses += $countones(outs());
            if (g_tick < 32) begin
                pl_mask[g_tick] = u_if.key_left;
                pr_mask[g_tick] = u_if.key_right;
                pd_mask[g_tick] = u_if.key_down;
            end
        end
        u_if.tick_game = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt [23];
        int          nz;
        int          lat;
        int          nrot;
        logic [4:0]  h;
        int unsigned flip_p [5];

        u_if.tick_game = 1'b0;
        u_if.enable    = 1'b1;
        model_reset();
        clr_rec();

`ifdef DEBOUNCE_EN
        set_held(5'b00000);
        repeat (3) step();
        rst = 1'b1;
        repeat (5) step();
        u_if.rotate_held = 1'b1;
        repeat (10) step();
        u_if.rotate_held = 1'b0;
        nrot = 0;
        repeat (40) begin
            step();
            nrot += int'(u_if.key_rotate);
        end
        check("deb_glitch", nrot, 0);
        u_if.rotate_held = 1'b1;
        lat  = 0;
        nrot = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (u_if.key_rotate) begin
                nrot++;
                if (lat == 0) lat = k;
            end
        end
        check("deb_latency", lat, 19);
        check("deb_count", nrot, 1);
`else
        // Reset with every key held: nothing may pulse after release.
        set_held(5'b11111);
        repeat (3) step();
        check("reset_outs", outs(), 5'b00000);
        rst = 1'b1;
        nz  = 0;
        for (int i = 0; i < 100; i++) begin
            u_if.tick_game = (i % 4 == 3);
            step();
            if (outs() != 5'b00000) nz++;
        end
        u_if.tick_game = 1'b0;
        check("reset_release_quiet", nz, 0);
        set_held(5'b00000);
        repeat (2) step();

        vt[0]  = '{tick:0, en:1, held:5'b00000, exp:5'b00000};
        vt[1]  = '{tick:0, en:1, held:5'b01000, exp:5'b01000};
        vt[2]  = '{tick:0, en:1, held:5'b01000, exp:5'b00000};
        vt[3]  = '{tick:0, en:1, held:5'b00000, exp:5'b00000};
        vt[4]  = '{tick:0, en:1, held:5'b11000, exp:5'b11000};
        vt[5]  = '{tick:1, en:1, held:5'b11000, exp:5'b00000};
        vt[6]  = '{tick:0, en:1, held:5'b00000, exp:5'b00000};
        vt[7]  = '{tick:0, en:1, held:5'b00001, exp:5'b00001};
        vt[8]  = '{tick:0, en:1, held:5'b00011, exp:5'b00010};
        vt[9]  = '{tick:0, en:1, held:5'b00001, exp:5'b00001};
        vt[10] = '{tick:0, en:1, held:5'b00000, exp:5'b00000};
        vt[11] = '{tick:0, en:1, held:5'b00011, exp:5'b00001};
        vt[12] = '{tick:0, en:1, held:5'b00010, exp:5'b00010};
        vt[13] = '{tick:0, en:1, held:5'b00000, exp:5'b00000};
        vt[14] = '{tick:0, en:1, held:5'b00100, exp:5'b00100};
        vt[15] = '{tick:1, en:1, held:5'b00100, exp:5'b00000};
        vt[16] = '{tick:1, en:1, held:5'b00100, exp:5'b00000};
        vt[17] = '{tick:1, en:1, held:5'b00100, exp:5'b00100};
        vt[18] = '{tick:1, en:1, held:5'b00101, exp:5'b00001};
        vt[19] = '{tick:0, en:1, held:5'b00101, exp:5'b00000};
        vt[20] = '{tick:0, en:0, held:5'b01000, exp:5'b00000};
        vt[21] = '{tick:0, en:1, held:5'b01000, exp:5'b00000};
        vt[22] = '{tick:0, en:1, held:5'b00000, exp:5'b00000};
        for (int i = 0; i < 23; i++) begin
            u_if.tick_game = vt[i].tick;
            u_if.enable    = vt[i].en;
            set_held(vt[i].held);
            step();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
        end
        u_if.tick_game = 1'b0;
        u_if.enable    = 1'b1;
        step();

        // Rotate held for 200 ticks: one pulse only.
        u_if.rotate_held = 1'b1;
        step();
        check("rot_press", outs(), 5'b01000);
        clr_rec();
        run_ticks(200);
        check("rot_hold_quiet", n_pulses, 0);
        u_if.rotate_held = 1'b0;
        step();

        // Left held 20 ticks: press, tick 10, then every 2 ticks.
        u_if.left_held = 1'b1;
        step();
        check("left_press", outs(), 5'b00001);
        clr_rec();
        run_ticks(20);
        check("left_mask", pl_mask, (32'd1 << 10) | (32'd1 << 12) | (32'd1 << 14) |
                                    (32'd1 << 16) | (32'd1 << 18) | (32'd1 << 20));
        check("left_no_right", pr_mask, 0);
        check("left_count", n_pulses, 6);
        check("left_stray", n_stray, 0);
        u_if.left_held = 1'b0;
        step();
        check("left_release", outs(), 5'b00000);

        // Newest press wins, release falls back to the still-held direction.
        u_if.left_held = 1'b1;
        step();
        check("sw_left_press", outs(), 5'b00001);
        clr_rec();
        run_ticks(5);
        check("sw_das_quiet", n_pulses, 0);
        u_if.right_held = 1'b1;
        step();
        check("sw_right_now", outs(), 5'b00010);
        clr_rec();
        run_ticks(3);
        check("sw_right_das_quiet", n_pulses, 0);
        u_if.right_held = 1'b0;
        step();
        check("sw_left_back", outs(), 5'b00001);
        clr_rec();
        run_ticks(10);
        check("sw_das_restart", pl_mask, 32'd1 << 10);
        check("sw_das_count", n_pulses, 1);
        u_if.left_held = 1'b0;
        step();

        // Soft drop repeat, then enable low mid-hold.
        u_if.down_held = 1'b1;
        step();
        check("down_press", outs(), 5'b00100);
        clr_rec();
        run_ticks(9);
        check("down_mask", pd_mask, (32'd1 << 3) | (32'd1 << 6) | (32'd1 << 9));
        check("down_count", n_pulses, 3);
        u_if.down_held = 1'b0;
        step();
        u_if.down_held = 1'b1;
        step();
        check("down2_press", outs(), 5'b00100);
        clr_rec();
        run_ticks(3);
        check("down2_tick3", pd_mask, 32'd1 << 3);
        u_if.enable = 1'b0;
        clr_rec();
        run_ticks(6);
        check("down2_disabled", n_pulses, 0);
        u_if.enable = 1'b1;
        clr_rec();
        run_ticks(9);
        check("down2_reenabled_held", n_pulses, 0);
        u_if.down_held = 1'b0;
        step();

        // Asynchronous reset while a repeat pulse is on the output.
        u_if.left_held = 1'b1;
        step();
        clr_rec();
        run_ticks(12);
        check("pre_reset_pulse", outs(), 5'b00001);
        #2 rst = 1'b0;
        #1 check("async_reset", outs(), 5'b00000);
        repeat (3) step();
        rst = 1'b1;
        clr_rec();
        run_ticks(25);
        check("post_reset_held_quiet", n_pulses, 0);
        u_if.left_held = 1'b0;
        repeat (2) step();

        // Random stimulus against the reference model.
        flip_p = '{96, 96, 48, 12, 12};
        for (int i = 0; i < 4000; i++) begin
            h = get_held();
            for (int b = 0; b < 5; b++)
                if ($urandom_range(flip_p[b] - 1) == 0) h[b] = ~h[b];
            set_held(h);
            u_if.tick_game = !u_if.tick_game && ($urandom_range(1) == 0);
            if (u_if.enable ? ($urandom_range(199) == 0) : ($urandom_range(19) == 0))
                u_if.enable = ~u_if.enable;
            step();
            check($sformatf("rand%0d", i), 32'(outs()), 32'(m_exp));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/input_manager.md
Name: input_manager

Overview:
- Converts held-key levels from the keyboard decoder into the single-cycle action pulses that game_control consumes (key_left, key_right, key_down, key_rotate, key_drop).
- Provides edge detection for rotate and hard drop.
- Provides delayed auto-shift (DAS) with auto-repeat for left/right, and auto-repeat for soft drop.
- Sits directly upstream of game_control. All repeat timing is paced by the 60 Hz tick_game.

Parameters:
- DAS_TICKS, 10, ticks a left/right key must be held after its initial pulse before the first auto-repeat pulse (1..255)
- ARR_TICKS, 2, ticks between successive left/right auto-repeat pulses (1..255)
- SOFT_DROP_TICKS, 3, ticks between successive soft-drop repeat pulses while down is held (1..255)
- DEBOUNCE_CYCLES, 16, clk cycles a raw level must be stable before it is accepted; used only with DEBOUNCE_EN (1..65535)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- tick_game  in  1  60 Hz single-cycle tick
- enable  in  1  0 = suppress all outputs and return to idle (driven low on game over)
- left_held  in  1  level, left key down
- right_held  in  1  level, right key down
- down_held  in  1  level, down key down
- rotate_held  in  1  level, rotate key down
- drop_held  in  1  level, hard-drop key down
- key_left  out  1  single-cycle pulse
- key_right  out  1  single-cycle pulse
- key_down  out  1  single-cycle pulse
- key_rotate  out  1  single-cycle pulse
- key_drop  out  1  single-cycle pulse

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0.
  - Previous-level registers 0.
  - Horizontal FSM in H_IDLE; all counters 0.
- All outputs are registered. Each pulse is high for exactly 1 clk.
- Latency: a 0->1 transition sampled on an input at edge N produces a pulse during cycle N+1.
- Rotate and drop:
  - Edge-triggered; exactly one pulse per 0->1 transition.
  - Holding the key never repeats.
  - If both edges occur in the same cycle, both pulses fire together; game_control resolves priority.
- Soft drop:
  - Pulse on the 0->1 edge of down_held, then clear the 8-bit soft-drop counter.
  - While held: each tick_game increments the counter. When it reaches SOFT_DROP_TICKS, pulse key_down and clear the counter.
  - Release clears the counter with no pulse.
- Horizontal FSM: states H_IDLE, H_DAS, H_REPEAT; a dir register (0 = left, 1 = right); an 8-bit tick counter.
  - H_IDLE + edge on left or right: pulse that direction, set dir, clear the counter, go to H_DAS.
  - H_IDLE + edges on both in the same cycle: left wins.
  - H_DAS: count ticks. When the count reaches DAS_TICKS, pulse dir, clear the counter, go to H_REPEAT.
  - H_REPEAT: count ticks. When the count reaches ARR_TICKS, pulse dir and clear the counter.
  - In H_DAS or H_REPEAT, a new edge on the opposite direction: newest press wins. Switch dir, pulse it immediately, clear the counter, go to H_DAS.
  - Active direction released while the opposite direction is still held: switch dir, pulse it, clear the counter, go to H_DAS.
  - Active direction released with the opposite direction not held: go to H_IDLE with no pulse.
  - key_left and key_right are never high in the same cycle.
- A tick_game arriving in the same cycle as a press edge is not counted; counting starts at the next tick.
- Counter comparisons use >=, so counters saturate safely and never wrap.
- enable low:
  - Outputs forced 0 the next cycle; horizontal FSM to H_IDLE; counters cleared.
  - Previous-level registers keep tracking the inputs, so keys already held when enable rises produce no pulse until they are released and pressed again.
- Reset asserted mid-repeat: immediate return to reset values; no pulse emitted on the cycle reset is released.

Optional Feature:
- Macro: DEBOUNCE_EN.
- Defined:
  - Each of the five *_held inputs passes through a 2-flop synchronizer and a per-input stability filter before edge detection.
  - The filtered level changes only after the raw level has held its new value for DEBOUNCE_CYCLES consecutive clk cycles.
  - Latency becomes DEBOUNCE_CYCLES+3 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Undefined: inputs are used directly; latency is 1 cycle as above.

Test Plan:
- Reset: hold rst low with all *_held=1; release rst -> no pulses; all outputs stay 0 for 100 cycles.
- Press rotate_held and hold for 200 ticks -> exactly one key_rotate pulse, 1 cycle after the edge. Press rotate and drop in the same cycle -> both pulse in the same cycle.
- Hold left_held for 20 ticks (defaults):
  - key_left pulses at press.
  - Next pulse at tick 10.
  - Further pulses at ticks 12, 14, 16, 18, 20.
  - Total 7 pulses, key_right never asserted.
- Hold left; at tick 5 also press right -> key_right pulses immediately, key_left stops. Release right at tick 8 with left still held -> key_left pulses immediately and DAS restarts.
- Hold down_held for 9 ticks -> key_down pulses at press and at ticks 3, 6, 9. Drive enable=0 at tick 4 -> no pulse at ticks 6 or 9, and none when enable returns high with down still held.
- With DEBOUNCE_EN and DEBOUNCE_CYCLES=16:
  - A 10-cycle glitch on rotate_held -> no pulse.
  - A 16-cycle stable press -> one pulse 19 cycles after the raw edge.
